// File: rtl/simon_key_expander_pkg.sv
// simon_pkg: shared constants and elaboration helpers for the SIMON key schedule.
//   Z0..Z4   : 62-bit z sequences, element 0 at bit 0
//   z_sel    : (n, m) -> z sequence index j
//   rounds   : (n, m) -> round count T
//   is_legal : (n, m) is one of the ten standard SIMON variants
//   state_t  : expander FSM states
package simon_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  // The published sequences read left to right from element 0; flip them so
  // element 0 lands at bit 0 and a right rotate walks the sequence.
  function automatic logic [61:0] rev62(input logic [61:0] s);
    logic [61:0] r;
    for (int i = 0; i < 62; i++) r[i] = s[61-i];
    return r;
  endfunction

  localparam logic [61:0] Z0 = rev62(62'b11111010_00100101_01100001_11001101_11110100_01001010_11000011_100110);
  localparam logic [61:0] Z1 = rev62(62'b10001110_11111001_00110000_10110101_00011101_11110010_01100001_011010);
  localparam logic [61:0] Z2 = rev62(62'b10101111_01110000_00110100_10011000_10100001_00011111_10010110_110011);
  localparam logic [61:0] Z3 = rev62(62'b11011011_10101100_01100101_11100000_01001000_10100111_00110100_001111);
  localparam logic [61:0] Z4 = rev62(62'b11010001_11100110_10110110_00100000_01011100_00110010_10010011_101111);

  function automatic bit is_legal(input int n, input int m);
    return (n == 16 && m == 4) ||
           (n == 24 && (m == 3 || m == 4)) ||
           (n == 32 && (m == 3 || m == 4)) ||
           (n == 48 && (m == 2 || m == 3)) ||
           (n == 64 && (m >= 2 && m <= 4));
  endfunction

  function automatic int z_sel(input int n, input int m);
    if (n == 16) return 0;
    if (n == 24) return (m == 3) ? 0 : 1;
    if (n == 32) return (m == 3) ? 2 : 3;
    if (n == 48) return (m == 2) ? 2 : 3;
    return m;  // n = 64: m=2..4 -> z2..z4
  endfunction

  function automatic logic [61:0] z_const(input int j);
    case (j)
      0:       return Z0;
      1:       return Z1;
      2:       return Z2;
      3:       return Z3;
      default: return Z4;
    endcase
  endfunction

  function automatic int rounds(input int n, input int m);
    case (n)
      16:      return 32;
      24:      return 36;
      32:      return (m == 3) ? 42 : 44;
      48:      return (m == 2) ? 52 : 54;
      64:      return (m == 2) ? 68 : ((m == 3) ? 69 : 72);
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/simon_key_expander_if.sv
// simon_key_expander_if: start/abort control plus the round-key valid/ready stream.
//   master : the controller/consumer side (drives start, abort, key, rk_ready)
//   slave  : the key expander itself
interface simon_key_expander_if #(
  parameter int WORD_W    = 64,
  parameter int KEY_WORDS = 2
);
  logic                        start_i;
  logic                        abort_i;
  logic [KEY_WORDS*WORD_W-1:0] key_i;
  logic                        ready_o;
  logic                        rk_valid_o;
  logic                        rk_ready_i;
  logic [WORD_W-1:0]           rk_o;
  logic [7:0]                  rk_idx_o;
  logic                        last_o;

  modport master (
    output start_i, abort_i, key_i, rk_ready_i,
    input  ready_o, rk_valid_o, rk_o, rk_idx_o, last_o
  );

  modport slave (
    input  start_i, abort_i, key_i, rk_ready_i,
    output ready_o, rk_valid_o, rk_o, rk_idx_o, last_o
  );
endinterface

// File: rtl/simon_key_expander_round.sv
// simon_key_round: one step of the SIMON key recurrence, purely combinational.
//   sr0  : k_i        (oldest word in the window)
//   sr1  : k_(i+1)    (only folded in when KEY_WORDS = 4)
//   srm  : k_(i+m-1)  (newest word)
//   zbit : z sequence element for this step
//   nxt  : k_(i+m)
// ~sr0 ^ 3 is the same as c ^ sr0 with c = 2^n - 4, so no wide constant is needed.
module simon_key_round #(
  parameter int WORD_W    = 64,
  parameter int KEY_WORDS = 2
) (
  input  logic [WORD_W-1:0] sr0,
  input  logic [WORD_W-1:0] sr1,
  input  logic [WORD_W-1:0] srm,
  input  logic              zbit,
  output logic [WORD_W-1:0] nxt
);
  logic [WORD_W-1:0] t_ror3, t_mix, t_fold;

  always_comb begin
    t_ror3 = {srm[2:0], srm[WORD_W-1:3]};
    t_mix  = t_ror3 ^ ((KEY_WORDS == 4) ? sr1 : '0);
    t_fold = t_mix ^ {t_mix[0], t_mix[WORD_W-1:1]};
    nxt    = ~sr0 ^ t_fold ^ WORD_W'(3) ^ {{(WORD_W-1){1'b0}}, zbit};
  end
endmodule

// File: rtl/simon_key_expander.sv
// simon_key_expander: loads an m-word SIMON master key and streams round keys
// k_0..k_(T-1) over a valid/ready handshake.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : simon_key_expander_if slave (start/abort/key in, round-key stream out)
// A KEY_WORDS-deep shift register holds the live window k_i..k_(i+m-1); sr[0]
// is the key on the output, and each handshake shifts in the next word.
module simon_key_expander
  import simon_pkg::*;
#(
  parameter int WORD_W    = 64,
  parameter int KEY_WORDS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  simon_key_expander_if.slave  bus
);
  localparam int          T        = rounds(WORD_W, KEY_WORDS);
  localparam logic [7:0]  IDX_LAST = 8'(T - 1);
  localparam logic [61:0] Z_INIT   = z_const(z_sel(WORD_W, KEY_WORDS));

  generate
    if (!is_legal(WORD_W, KEY_WORDS)) begin : g_bad_cfg
      $fatal(1, "simon_key_expander: (WORD_W, KEY_WORDS) is not a standard SIMON variant");
    end
  endgenerate

  state_t                             state, state_nx;
  logic [KEY_WORDS-1:0][WORD_W-1:0]   sr;
  logic [61:0]                        z_reg;
  logic [7:0]                         idx;
  logic [WORD_W-1:0]                  new_w;
  logic                               load, adv, is_last, hs;

  simon_key_round #(.WORD_W(WORD_W), .KEY_WORDS(KEY_WORDS)) u_round (
    .sr0  (sr[0]),
    .sr1  (sr[1]),
    .srm  (sr[KEY_WORDS-1]),
    .zbit (z_reg[0]),
    .nxt  (new_w)
  );

  assign is_last = (state == RUN) && (idx == IDX_LAST);
  assign hs      = (state == RUN) && bus.rk_ready_i;

  // Abort wins over both start and the handshake. The final handshake leaves
  // the window untouched so rk_o/rk_idx_o keep showing k_(T-1) in IDLE.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    adv      = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.abort_i && bus.start_i) begin
          state_nx = RUN;
          load     = 1'b1;
        end
      end
      RUN: begin
        if (bus.abort_i) begin
          state_nx = IDLE;
        end else if (hs) begin
          if (is_last) state_nx = IDLE;
          else         adv      = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr    <= '0;
      z_reg <= '0;
      idx   <= '0;
    end else if (load) begin
      for (int j = 0; j < KEY_WORDS; j++) sr[j] <= bus.key_i[j*WORD_W +: WORD_W];
      z_reg <= Z_INIT;
      idx   <= '0;
    end else if (adv) begin
      for (int j = 0; j < KEY_WORDS-1; j++) sr[j] <= sr[j+1];
      sr[KEY_WORDS-1] <= new_w;
      z_reg           <= {z_reg[0], z_reg[61:1]};
      idx             <= idx + 8'd1;
    end
  end

  assign bus.ready_o    = (state == IDLE);
  assign bus.rk_valid_o = (state == RUN);
  assign bus.rk_o       = sr[0];
  assign bus.rk_idx_o   = idx;
  assign bus.last_o     = is_last;
endmodule
